// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory sequencer/arbiter.
//   state_t      : top-level sequencer states (IDLE, ACCESS, INIT)
//   MEM_BYTES    : data memory size in bytes
//   INIT_WORDS   : number of words written by the preload sequence
//   WORD_BYTES   : bytes per memory word
//   init_word()  : preload value of word k (k+1, except the last word is 0)
package dmem_pkg;

  localparam int MEM_BYTES  = 44;
  localparam int INIT_WORDS = 11;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    INIT   = 2'd2
  } state_t;

  // Preload contents: word k holds k+1, the final word (index n-1) holds 0.
  function automatic logic [31:0] init_word(input int k, input int n);
    return (k < n - 1) ? 32'(k + 1) : 32'd0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
//   req        in  2  eligible requests, bit N = port N
//   last_grant in  1  port that won the previous grant
//   grant      out 2  one-hot grant, 0 when nothing is requested
// On a tie the port that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer and arbiter in front of the big-endian data memory.
// Shares the single memory port between port 0 (CPU) and port 1 (debug/loader)
// and runs a preload sequence that writes the power-on memory image.
// Every access takes one memory cycle; ackN pulses one cycle later.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start / busy                preload request pulse / preload pending or running
//   req/we/addr/wdata/ack/rdata per-port registered handshake (suffix 0 and 1)
//   err                         access error, valid alongside either ack
//   Address, WriteData,         memory port; Address/WriteData hold their
//   MemWrite, MemRead           last value outside ACCESS and INIT
//   ReadData                    combinational memory read data
//
// Build option: define DMEM_BOUNDS_CHECK_EN to reject misaligned or
// out-of-range addresses (no memory strobe, ack with err = 1, rdata = 0).
// Without it err is always 0 and every address reaches the memory.
module dmem_arbiter #(
  parameter int MEM_BYTES  = dmem_pkg::MEM_BYTES,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int INIT_WORDS = dmem_pkg::INIT_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData
);

  import dmem_pkg::*;

  localparam int            CW       = $clog2(INIT_WORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(INIT_WORDS - 1);

  state_t        state, state_nx;
  logic          last_grant;
  logic          start_pend;
  logic [CW-1:0] cnt;
  logic          cap_we, cap_port, cap_bad;

  logic [1:0]    elig, grant;
  logic          sel_we, sel_bad, chk_en;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, rd_val;

  // A port still showing its ack is not eligible, so a held req cannot be
  // granted a second time in its own ack cycle.
  assign elig = {req1 & ~ack1, req0 & ~ack0};

  rr_arb2 u_arb (
    .req        (elig),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_we    = grant[1] ? we1    : we0;
  assign sel_addr  = grant[1] ? addr1  : addr0;
  assign sel_wdata = grant[1] ? wdata1 : wdata0;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign chk_en = 1'b1;
`else
  assign chk_en = 1'b0;
`endif

  // Valid word addresses are aligned and leave room for a full word.
  assign sel_bad = chk_en & ((sel_addr[1:0] != 2'b00) ||
                             (sel_addr > AW'(MEM_BYTES - WORD_BYTES)));

  // Writes and rejected accesses return zero to the requester.
  assign rd_val = (cap_we | cap_bad) ? '0 : ReadData;

  assign busy = (state == INIT) | start_pend;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a pending preload outranks port requests.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start || start_pend) state_nx = INIT;
        else if (|grant)         state_nx = ACCESS;
      end
      ACCESS:  state_nx = IDLE;
      INIT:    if (cnt == LAST_CNT) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes follow the state directly, so an asynchronous reset drops
  // them before the next clock edge.
  always_comb begin
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    case (state)
      ACCESS: begin
        MemWrite = cap_we  & ~cap_bad;
        MemRead  = ~cap_we & ~cap_bad;
      end
      INIT:    MemWrite = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture, preload counter, handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only control and port registers are reset; the external memory is
    // never cleared here, so an interrupted preload leaves a partial image.
    if (rst) begin
      last_grant <= 1'b1;
      start_pend <= 1'b0;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_port   <= 1'b0;
      cap_bad    <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;

      // IDLE always consumes a pending start (it goes straight to INIT);
      // repeated pulses elsewhere just keep the flag set.
      if (state == IDLE) start_pend <= 1'b0;
      else if (start)    start_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (state_nx == INIT) begin
            cnt       <= '0;
            Address   <= '0;
            WriteData <= DW'(init_word(0, INIT_WORDS));
          end else if (state_nx == ACCESS) begin
            last_grant <= grant[1];
            cap_port   <= grant[1];
            cap_we     <= sel_we;
            cap_bad    <= sel_bad;
            Address    <= sel_addr;
            WriteData  <= sel_wdata;
          end
        end
        ACCESS: begin
          err <= cap_bad;
          if (cap_port) begin
            ack1   <= 1'b1;
            rdata1 <= rd_val;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= rd_val;
          end
        end
        INIT: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
          end else begin
            cnt       <= cnt + CW'(1);
            Address   <= (AW'(cnt) + AW'(1)) << 2;
            WriteData <= DW'(init_word(int'(cnt) + 1, INIT_WORDS));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reset state, preload sequence,
// table of single-port accesses, arbitration, preload/request interaction,
// pending start, reset during access, bounds option, randomized traffic
// against a word-level memory model.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BYTES = 44;
  localparam int WORDS = 11;

  logic          clk = 1'b0;
  logic          rst, start, busy;
  logic          req0, we0, ack0, req1, we1, ack1, err;
  logic [AW-1:0] addr0, addr1, Address;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, WriteData, ReadData;
  logic          MemWrite, MemRead;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err(err), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  // Byte-wide big-endian data memory attached to the DUT's port.
  logic [7:0] mem [0:BYTES-1];

  always_comb begin
    ReadData = '0;
    for (int i = 0; i < 4; i++) begin
      if (int'(Address) + i >= 0 && int'(Address) + i < BYTES)
        ReadData[8*(3-i) +: 8] = mem[int'(Address) + i];
    end
  end

  always @(posedge clk) begin
    if (MemWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (int'(Address) + i >= 0 && int'(Address) + i < BYTES)
          mem[int'(Address) + i] <= WriteData[8*(3-i) +: 8];
      end
    end
  end

  // Activity monitor
  int mw_cnt = 0, mr_cnt = 0, dual_ack = 0, stray_err = 0;
  always @(negedge clk) begin
    if (MemWrite) mw_cnt++;
    if (MemRead) mr_cnt++;
    if (ack0 && ack1) dual_ack++;
    if (err && !(ack0 || ack1)) stray_err++;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Word-level model of the memory image.
  logic [31:0] exp_mem [0:WORDS-1];

  task automatic load_preload_model();
    for (int k = 0; k < WORDS; k++) exp_mem[k] = (k < WORDS - 1) ? 32'(k + 1) : 32'd0;
  endtask

  // One access on port p; entered and left on a negedge. Returns the data and
  // err seen with the ack and the number of negedges from req to ack (-1 = none).
  task automatic do_access(input bit p, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic e, output int lat);
    logic [31:0] other_before;
    @(negedge clk);
    other_before = p ? rdata0 : rdata1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    lat = -1; rd = '0; e = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if ((p ? ack1 : ack0) === 1'b1) begin
        lat = c; rd = p ? rdata1 : rdata0; e = err;
        break;
      end
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
    check("other_rdata_hold", p ? rdata0 : rdata1, other_before);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] rd;
  logic        e;
  int          lat, nb, nw, snap_w, snap_r, snap_d, idle_at, ack_at, n0, n1;
  int          order [$];
  bit          r_act [2];
  bit          r_we  [2];
  logic [31:0] r_a   [2];
  logic [31:0] r_d   [2];
  int          r_wt  [2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'd36, 32'd0,        32'h0000000A};
    tbl[1] = '{1'b0, 1'b0, 32'd40, 32'd0,        32'h00000000};
    tbl[2] = '{1'b0, 1'b0, 32'd0,  32'd0,        32'h00000001};
    tbl[3] = '{1'b0, 1'b1, 32'd8,  32'hDEADBEEF, 32'h00000000};
    tbl[4] = '{1'b0, 1'b0, 32'd8,  32'd0,        32'hDEADBEEF};
    tbl[5] = '{1'b1, 1'b0, 32'd20, 32'd0,        32'h00000006};
    tbl[6] = '{1'b1, 1'b1, 32'd16, 32'h12345678, 32'h00000000};
    tbl[7] = '{1'b0, 1'b0, 32'd16, 32'd0,        32'h12345678};
    tbl[8] = '{1'b1, 1'b0, 32'd8,  32'd0,        32'hDEADBEEF};

    rst = 1'b1; start = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_err", err, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_memread", MemRead, 0);
    check("rst_address", Address, 0);
    check("rst_writedata", WriteData, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);

    // Preload: 11 write cycles at 4k with k+1, last word 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nw = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) nb++;
      if (MemWrite) nw++;
      if (i < WORDS) begin
        check($sformatf("init_addr_%0d", i), Address, 32'(4 * i));
        check($sformatf("init_wdata_%0d", i), WriteData, (i < WORDS - 1) ? 32'(i + 1) : 32'd0);
      end
      @(negedge clk);
    end
    check("init_busy_cycles", 32'(nb), 11);
    check("init_write_cycles", 32'(nw), 11);
    load_preload_model();

    // Table of single accesses
    for (int i = 0; i < 9; i++) begin
      do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, e, lat);
      check($sformatf("tbl_rdata_%0d", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl_err_%0d", i), e, 0);
      check($sformatf("tbl_latency_%0d", i), 32'(lat), 2);
      if (tbl[i].we) exp_mem[tbl[i].addr >> 2] = tbl[i].wdata;
    end

    // Simultaneous requests, held and re-raised: grants alternate from port 0
    snap_d = dual_ack;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    n0 = 0; n1 = 0;
    order.delete();
    for (int c = 0; c < 30 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ack0) begin
        order.push_back(0);
        check("arb_rdata0", rdata0, exp_mem[addr0 >> 2]);
        n0++;
        if (n0 < 2) addr0 = 32'd8; else req0 = 1'b0;
      end
      if (ack1) begin
        order.push_back(1);
        check("arb_rdata1", rdata1, exp_mem[addr1 >> 2]);
        n1++;
        if (n1 < 2) addr1 = 32'd12; else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("arb_grants", 32'(order.size()), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(i % 2));
    check("arb_no_dual_ack", 32'(dual_ack - snap_d), 0);

    // Request raised in INIT cycle 3 waits until after the preload
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd24;
    idle_at = -1; ack_at = -1; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!busy && idle_at < 0) idle_at = i;
      if (ack1 && ack_at < 0) begin
        ack_at = i; rd = rdata1; req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    load_preload_model();
    check("init_req_ack_seen", 32'(ack_at > 0), 1);
    check("init_req_first_idle", 32'(idle_at), 8);
    check("init_req_ack_delay", 32'(ack_at - idle_at), 2);
    check("init_req_rdata", rd, exp_mem[6]);

    // start during ACCESS is remembered; extra pulses during INIT collapse
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    @(negedge clk);
    check("pend_access_memread", MemRead, 1);
    check("pend_access_addr", Address, 0);
    start = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    check("pend_ack0", ack0, 1);
    check("pend_rdata0", rdata0, exp_mem[0]);
    check("pend_busy", busy, 1);
    nb = 0; snap_w = mw_cnt;
    for (int i = 0; i < 30; i++) begin
      start = (i == 3 || i == 5);
      if (busy) nb++;
      @(negedge clk);
    end
    start = 1'b0;
    check("pend_busy_cycles", 32'(nb), 24);
    check("pend_write_cycles", 32'(mw_cnt - snap_w), 22);

    // Reset in the ACCESS cycle of a write: no strobe at the edge, no ack
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'h55;
    @(negedge clk);
    check("rstacc_memwrite_before", MemWrite, 1);
    check("rstacc_address", Address, 12);
    rst = 1'b1;
    #1;
    check("rstacc_memwrite_drop", MemWrite, 0);
    req0 = 1'b0;
    @(negedge clk);
    check("rstacc_no_ack0", ack0, 0);
    rst = 1'b0;
    do_access(1'b0, 1'b0, 32'd12, 32'd0, rd, e, lat);
    check("rstacc_mem_kept", rd, exp_mem[3]);
    check("rstacc_read_latency", 32'(lat), 2);

    // Bounds option
    snap_w = mw_cnt; snap_r = mr_cnt;
`ifdef DMEM_BOUNDS_CHECK_EN
    do_access(1'b0, 1'b0, 32'd42, 32'd0, rd, e, lat);
    check("bnd_rd42_err", e, 1);
    check("bnd_rd42_rdata", rd, 0);
    check("bnd_rd42_latency", 32'(lat), 2);
    do_access(1'b0, 1'b1, 32'd6, 32'hFFFFFFFF, rd, e, lat);
    check("bnd_wr6_err", e, 1);
    check("bnd_wr6_rdata", rd, 0);
    check("bnd_wr6_latency", 32'(lat), 2);
    check("bnd_no_memwrite", 32'(mw_cnt - snap_w), 0);
    check("bnd_no_memread", 32'(mr_cnt - snap_r), 0);
    do_access(1'b0, 1'b0, 32'd4, 32'd0, rd, e, lat);
    check("bnd_word4_intact", rd, exp_mem[1]);
    check("bnd_word4_err", e, 0);
`else
    do_access(1'b0, 1'b0, 32'd42, 32'd0, rd, e, lat);
    check("nobnd_rd42_err", e, 0);
    check("nobnd_rd42_latency", 32'(lat), 2);
    check("nobnd_rd42_memread", 32'(mr_cnt - snap_r), 1);
    do_access(1'b0, 1'b0, 32'd4, 32'd0, rd, e, lat);
    check("nobnd_word4", rd, exp_mem[1]);
    check("nobnd_word4_err", e, 0);
`endif

    // Randomized two-port traffic against the word model
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin r_act[p] = 1'b0; r_wt[p] = 0; end
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (r_act[p]) begin
          r_wt[p]++;
          if ((p == 1) ? ack1 : ack0) begin
            check("rnd_rdata", (p == 1) ? rdata1 : rdata0,
                  r_we[p] ? 32'd0 : exp_mem[r_a[p] >> 2]);
            check("rnd_err", err, 0);
            check("rnd_wait_bound", 32'(r_wt[p] <= 8), 1);
            if (r_we[p]) exp_mem[r_a[p] >> 2] = r_d[p];
            r_act[p] = 1'b0;
          end else if (r_wt[p] > 12) begin
            check("rnd_timeout", 0, 1);
            r_act[p] = 1'b0;
          end
        end
        if (!r_act[p] && cyc < 400 && $urandom_range(0, 1) == 1) begin
          r_act[p] = 1'b1;
          r_wt[p]  = 0;
          r_we[p]  = 1'($urandom_range(0, 1));
          r_a[p]   = 32'(4 * $urandom_range(0, WORDS - 1));
          r_d[p]   = $urandom;
        end
      end
      req0 = r_act[0]; we0 = r_we[0]; addr0 = r_a[0]; wdata0 = r_d[0];
      req1 = r_act[1]; we1 = r_we[1]; addr1 = r_a[1]; wdata1 = r_d[1];
    end
    check("rnd_drained", 32'(r_act[0] | r_act[1]), 0);

    check("never_dual_ack", 32'(dual_ack), 0);
    check("err_only_with_ack", 32'(stray_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
